// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell/result/error encodings and FSM states.
package ttt_pkg;

   localparam int unsigned NUM_CELLS  = 9;
   localparam int unsigned CELL_W     = 2;
   localparam int unsigned BOARD_W    = NUM_CELLS * CELL_W;
   localparam int unsigned CELL_IDX_W = 4;
   localparam int unsigned COUNT_W    = 4;

   localparam logic [CELL_W-1:0] CELL_EMPTY  = 2'b00;
   localparam logic [CELL_W-1:0] CELL_X      = 2'b01;
   localparam logic [CELL_W-1:0] CELL_O      = 2'b10;
   localparam logic [CELL_W-1:0] RESULT_DRAW = 2'b11;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_RANGE    = 2'b01;
   localparam logic [1:0] ERR_OCCUPIED = 2'b10;
   localparam logic [1:0] ERR_TURN     = 2'b11;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'b00,
      ST_CHECK = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // Opponent of the given player.
   function automatic logic [CELL_W-1:0] other_player(input logic [CELL_W-1:0] p);
      return (p == CELL_X) ? CELL_O : CELL_X;
   endfunction

endpackage

// File: rtl/cell_mux.sv
// 9:1 read of one 2-bit board cell; out-of-range indices read as empty.
module cell_mux
   import ttt_pkg::*;
(
   input  logic [BOARD_W-1:0]    board_i,
   input  logic [CELL_IDX_W-1:0] idx_i,
   output logic [CELL_W-1:0]     cell_c
);

   // Select the addressed cell, defaulting to empty.
   always_comb begin
      cell_c = CELL_EMPTY;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (idx_i == CELL_IDX_W'(i)) begin
            cell_c = board_i[CELL_W*i +: CELL_W];
         end
      end
   end

endmodule

// File: rtl/board_writer.sv
// Board-state owner and move sequencer: validates moves, writes the board,
// alternates turns and resolves win/draw from the external win result.
module board_writer
   import ttt_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   new_game,
   input  logic                   move_valid,
   output logic                   move_ready,
   input  logic [CELL_W-1:0]      move_player,
   input  logic [CELL_IDX_W-1:0]  move_cell,
   input  logic [CELL_W-1:0]      winner_in,
   output logic [BOARD_W-1:0]     board,
   output logic [CELL_W-1:0]      turn,
   output logic [COUNT_W-1:0]     move_count,
   output logic                   move_ok,
   output logic                   move_err,
   output logic [1:0]             err_code,
   output logic                   game_over,
   output logic [CELL_W-1:0]      result
);

   state_e               state_q, state_d;
   logic [BOARD_W-1:0]   board_q, board_d;
   logic [CELL_W-1:0]    turn_q, turn_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 ok_q, ok_d;
   logic                 err_q, err_d;
   logic [1:0]           err_code_q, err_code_d;
   logic                 ready_q, ready_d;
   logic                 game_over_q, game_over_d;
   logic [CELL_W-1:0]    result_q, result_d;

   logic [CELL_W-1:0]    target_c;
   logic [CELL_W-1:0]    winner_c;
   logic                 accept_c;

   cell_mux u_cell_mux (
      .board_i (board_q),
      .idx_i   (move_cell),
      .cell_c  (target_c)
   );

   // Invalid win codes (11) count as no winner.
   assign winner_c = (winner_in == CELL_X || winner_in == CELL_O) ? winner_in : CELL_EMPTY;
   assign accept_c = move_valid && ready_q;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      turn_d      = turn_q;
      count_d     = count_q;
      ok_d        = 1'b0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      result_d    = result_q;

      if (new_game) begin
         state_d  = ST_PLAY;
         board_d  = '0;
         turn_d   = CELL_X;
         count_d  = '0;
         result_d = CELL_EMPTY;
      end else begin
         case (state_q)
            ST_PLAY: begin
               if (accept_c) begin
                  if (move_cell > CELL_IDX_W'(NUM_CELLS - 1)) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_RANGE;
                  end else if (target_c != CELL_EMPTY) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_OCCUPIED;
                  end else if (move_player != turn_q) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_TURN;
                  end else begin
                     for (int i = 0; i < NUM_CELLS; i++) begin
                        if (move_cell == CELL_IDX_W'(i)) begin
                           board_d[CELL_W*i +: CELL_W] = move_player;
                        end
                     end
                     count_d = count_q + COUNT_W'(1);
                     ok_d    = 1'b1;
                     state_d = ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if (winner_c != CELL_EMPTY) begin
                  result_d = winner_c;
                  state_d  = ST_DONE;
               end else if (count_q == COUNT_W'(NUM_CELLS)) begin
                  result_d = RESULT_DRAW;
                  state_d  = ST_DONE;
               end else begin
                  turn_d  = other_player(turn_q);
                  state_d = ST_PLAY;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_PLAY;
            end
         endcase
      end

      ready_d     = (state_d == ST_PLAY);
      game_over_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PLAY;
         board_q     <= '0;
         turn_q      <= CELL_X;
         count_q     <= '0;
         ok_q        <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         ready_q     <= 1'b1;
         game_over_q <= 1'b0;
         result_q    <= CELL_EMPTY;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         turn_q      <= turn_d;
         count_q     <= count_d;
         ok_q        <= ok_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         ready_q     <= ready_d;
         game_over_q <= game_over_d;
         result_q    <= result_d;
      end
   end

   assign move_ready = ready_q;
   assign board      = board_q;
   assign turn       = turn_q;
   assign move_count = count_q;
   assign move_ok    = ok_q;
   assign move_err   = err_q;
   assign err_code   = err_code_q;
   assign game_over  = game_over_q;
   assign result     = result_q;

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer with a behavioural line checker on winner_in.
module tb_board_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        new_game;
   logic        move_valid;
   logic        move_ready;
   logic [1:0]  move_player;
   logic [3:0]  move_cell;
   logic [1:0]  winner_in;
   logic [17:0] board;
   logic [1:0]  turn;
   logic [3:0]  move_count;
   logic        move_ok;
   logic        move_err;
   logic [1:0]  err_code;
   logic        game_over;
   logic [1:0]  result;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] PX = 2'b01;
   localparam logic [1:0] PO = 2'b10;

   board_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .new_game    (new_game),
      .move_valid  (move_valid),
      .move_ready  (move_ready),
      .move_player (move_player),
      .move_cell   (move_cell),
      .winner_in   (winner_in),
      .board       (board),
      .turn        (turn),
      .move_count  (move_count),
      .move_ok     (move_ok),
      .move_err    (move_err),
      .err_code    (err_code),
      .game_over   (game_over),
      .result      (result)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] cell_of(input logic [17:0] b, input int i);
      return b[2*i +: 2];
   endfunction

   function automatic logic [1:0] line3(input logic [17:0] b, input int a, input int c, input int d);
      logic [1:0] x;
      x = cell_of(b, a);
      if (x != 2'b00 && x == cell_of(b, c) && x == cell_of(b, d)) return x;
      return 2'b00;
   endfunction

   // Environment win checker: OR of the eight line results.
   always_comb begin
      winner_in = line3(board, 0, 1, 2) | line3(board, 3, 4, 5) | line3(board, 6, 7, 8)
                | line3(board, 0, 3, 6) | line3(board, 1, 4, 7) | line3(board, 2, 5, 8)
                | line3(board, 0, 4, 8) | line3(board, 2, 4, 6);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic try_move(input logic [1:0] p, input logic [3:0] c);
      move_valid  = 1'b1;
      move_player = p;
      move_cell   = c;
      tick();
      move_valid  = 1'b0;
   endtask

   logic [3:0] win_cells  [5] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
   logic [3:0] draw_cells [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

   initial begin
      rst_n       = 1'b0;
      new_game    = 1'b0;
      move_valid  = 1'b0;
      move_player = PX;
      move_cell   = 4'd0;
      #12;
      check_eq("rst_board", 32'(board), 32'h0);
      check_eq("rst_turn", 32'(turn), 32'h1);
      check_eq("rst_count", 32'(move_count), 32'h0);
      check_eq("rst_ready", 32'(move_ready), 32'h1);
      check_eq("rst_ok", 32'(move_ok), 32'h0);
      check_eq("rst_err", 32'(move_err), 32'h0);
      check_eq("rst_over", 32'(game_over), 32'h0);
      check_eq("rst_result", 32'(result), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Rejections from an empty board on X's turn.
      try_move(PX, 4'd9);
      check_eq("range_err", 32'(move_err), 32'h1);
      check_eq("range_code", 32'(err_code), 32'h1);
      check_eq("range_ok", 32'(move_ok), 32'h0);
      check_eq("range_board", 32'(board), 32'h0);
      try_move(PO, 4'd0);
      check_eq("turn_err", 32'(move_err), 32'h1);
      check_eq("turn_code", 32'(err_code), 32'h3);
      try_move(PO, 4'd12);
      check_eq("prio_code", 32'(err_code), 32'h1);
      tick();
      check_eq("err_pulse_end", 32'(move_err), 32'h0);
      check_eq("err_code_clr", 32'(err_code), 32'h0);

      // Back-to-back rejections while valid stays high.
      move_valid = 1'b1; move_player = PX; move_cell = 4'd9;
      tick();
      check_eq("b2b_err1", 32'(move_err), 32'h1);
      check_eq("b2b_ready", 32'(move_ready), 32'h1);
      tick();
      check_eq("b2b_err2", 32'(move_err), 32'h1);
      move_valid = 1'b0;

      // Legal move then occupied replay.
      try_move(PX, 4'd0);
      check_eq("legal_ok", 32'(move_ok), 32'h1);
      check_eq("legal_board", 32'(board), 32'h1);
      check_eq("legal_count", 32'(move_count), 32'h1);
      check_eq("check_ready", 32'(move_ready), 32'h0);
      tick();
      check_eq("after_check_ready", 32'(move_ready), 32'h1);
      check_eq("after_check_turn", 32'(turn), 32'h2);
      check_eq("after_check_ok", 32'(move_ok), 32'h0);
      try_move(PO, 4'd0);
      check_eq("occ_err", 32'(move_err), 32'h1);
      check_eq("occ_code", 32'(err_code), 32'h2);
      check_eq("occ_board", 32'(board), 32'h1);
      check_eq("occ_count", 32'(move_count), 32'h1);

      // new_game collides with a valid move.
      move_valid = 1'b1; move_player = PO; move_cell = 4'd4; new_game = 1'b1;
      tick();
      move_valid = 1'b0; new_game = 1'b0;
      check_eq("ng_ok", 32'(move_ok), 32'h0);
      check_eq("ng_err", 32'(move_err), 32'h0);
      check_eq("ng_board", 32'(board), 32'h0);
      check_eq("ng_turn", 32'(turn), 32'h1);
      check_eq("ng_count", 32'(move_count), 32'h0);
      check_eq("ng_ready", 32'(move_ready), 32'h1);

      // X win with move_valid held high throughout.
      for (int k = 0; k < 5; k++) begin
         move_valid  = 1'b1;
         move_player = (k % 2 == 0) ? PX : PO;
         move_cell   = win_cells[k];
         tick();
         check_eq("win_ok", 32'(move_ok), 32'h1);
         tick();
         check_eq("win_gap_ok", 32'(move_ok), 32'h0);
         check_eq("win_gap_err", 32'(move_err), 32'h0);
      end
      check_eq("win_over", 32'(game_over), 32'h1);
      check_eq("win_result", 32'(result), 32'h1);
      check_eq("win_count", 32'(move_count), 32'h5);
      check_eq("win_board", 32'(board), 32'h295);
      check_eq("win_ready", 32'(move_ready), 32'h0);

      // Requests in DONE are ignored silently.
      move_player = PO; move_cell = 4'd5;
      for (int k = 0; k < 2; k++) begin
         tick();
         check_eq("done_ok", 32'(move_ok), 32'h0);
         check_eq("done_err", 32'(move_err), 32'h0);
      end
      check_eq("done_board", 32'(board), 32'h295);
      check_eq("done_count", 32'(move_count), 32'h5);
      check_eq("done_result", 32'(result), 32'h1);
      move_valid = 1'b0;

      // new_game leaves DONE.
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check_eq("ng_done_over", 32'(game_over), 32'h0);
      check_eq("ng_done_result", 32'(result), 32'h0);
      check_eq("ng_done_ready", 32'(move_ready), 32'h1);
      check_eq("ng_done_board", 32'(board), 32'h0);

      // Full-board draw.
      for (int k = 0; k < 9; k++) begin
         try_move((k % 2 == 0) ? PX : PO, draw_cells[k]);
         check_eq("draw_ok", 32'(move_ok), 32'h1);
         check_eq("draw_count", 32'(move_count), 32'(k + 1));
         tick();
      end
      check_eq("draw_result", 32'(result), 32'h3);
      check_eq("draw_over", 32'(game_over), 32'h1);
      check_eq("draw_count9", 32'(move_count), 32'h9);
      check_eq("draw_ready", 32'(move_ready), 32'h0);
      check_eq("draw_board", 32'(board), 32'h16A59);

      // Async reset during CHECK.
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      try_move(PX, 4'd4);
      check_eq("pre_rst_ready", 32'(move_ready), 32'h0);
      check_eq("pre_rst_board", 32'(board), 32'h100);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_board", 32'(board), 32'h0);
      check_eq("arst_count", 32'(move_count), 32'h0);
      check_eq("arst_ready", 32'(move_ready), 32'h1);
      check_eq("arst_ok", 32'(move_ok), 32'h0);
      check_eq("arst_turn", 32'(turn), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_ready", 32'(move_ready), 32'h1);
      check_eq("post_rst_over", 32'(game_over), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
